// File: rtl/cpu_pkg.sv
// Shared encodings for the 5-stage MIPS core: opcodes, functs, hazard FSM
// states, forwarding selects and the decode/scoreboard record types.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SLT   = 6'd42;

  localparam logic [1:0] FWD_REG  = 2'd0;
  localparam logic [1:0] FWD_MEM  = 2'd1;
  localparam logic [1:0] FWD_WB   = 2'd2;
  localparam logic [1:0] FWD_WBYP = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0] dst;
    logic       ld;
  } sb_ent_t;

  typedef struct packed {
    logic [4:0] src_a;
    logic [4:0] src_b;
    logic       use_a;
    logic       use_b;
    logic [4:0] dst;
    logic       is_ld;
    logic       is_j;
  } dec_t;

endpackage

// File: rtl/hz_decode.sv
// Decode-stage register usage extraction; register 0 is folded away here so
// later comparisons never see it as a live source.
module hz_decode
  import cpu_pkg::*;
(
  input  logic [31:0] ir_i,
  input  logic        valid_i,
  output dec_t        dec_o
);

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;
  logic       unused_shamt;

  assign op           = ir_i[31:26];
  assign rs           = ir_i[25:21];
  assign rt           = ir_i[20:16];
  assign rd           = ir_i[15:11];
  assign fn           = ir_i[5:0];
  assign unused_shamt = ^ir_i[10:6];

  always_comb begin
    dec_o       = '0;
    dec_o.src_a = rs;
    dec_o.src_b = rt;
    if (valid_i) begin
      case (op)
        OP_RTYPE: if (fn == FN_ADD || fn == FN_SUB || fn == FN_SLT) begin
          dec_o.use_a = 1'b1;
          dec_o.use_b = 1'b1;
          dec_o.dst   = rd;
        end
        OP_LW: begin
          dec_o.use_a = 1'b1;
          dec_o.dst   = rt;
          dec_o.is_ld = 1'b1;
        end
        OP_SW, OP_BEQ: begin
          dec_o.use_a = 1'b1;
          dec_o.use_b = 1'b1;
        end
        OP_J:    dec_o.is_j = 1'b1;
        default: ;
      endcase
    end
    if (rs == 5'd0) dec_o.use_a = 1'b0;
    if (rt == 5'd0) dec_o.use_b = 1'b0;
  end

endmodule

// File: rtl/hazard_sched.sv
// Hazard controller: 3-entry destination scoreboard (EX/MEM/WB), load-use
// stall, branch/jump flush, registered forwarding selects, perf counters.
module hazard_sched
  import cpu_pkg::*;
#(
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_LEN = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_ir,
  input  logic             if_valid,
  input  logic             ex_br_taken,
  output logic             pc_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] LL_M1 = 2'(LOAD_LAT - 1);
  localparam logic [1:0] FL_M1 = 2'(FLUSH_LEN - 1);

  dec_t             dec;
  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  sb_ent_t          sb1_q, sb2_q, sb3_q, push;
  logic [1:0]       fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             load_use;

  hz_decode u_dec (
    .ir_i    (if_ir),
    .valid_i (if_valid),
    .dec_o   (dec)
  );

  // Youngest producer wins; sources arrive with register 0 already masked.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic use_src,
                                         input sb_ent_t s1, input sb_ent_t s2,
                                         input sb_ent_t s3);
    if (!use_src)       return FWD_REG;
    if (s1.dst == src)  return FWD_MEM;
    if (s2.dst == src)  return FWD_WB;
    if (s3.dst == src)  return FWD_WBYP;
    return FWD_REG;
  endfunction

  assign load_use = sb1_q.ld &&
                    ((dec.use_a && dec.src_a == sb1_q.dst) ||
                     (dec.use_b && dec.src_b == sb1_q.dst));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_hold     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (ex_br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (FLUSH_LEN > 1) begin
        state_d = ST_FLUSH;
        cnt_d   = FL_M1;
      end else begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (load_use) begin
            pc_hold     = 1'b1;
            idex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = ST_STALL;
              cnt_d   = LL_M1;
            end
          end else if (dec.is_j) begin
            ifid_flush = 1'b1;
          end
        end
        ST_STALL: begin
          pc_hold     = 1'b1;
          idex_bubble = 1'b1;
          cnt_d       = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = ST_RUN;
        end
        ST_FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          cnt_d       = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign push = idex_bubble ? '0 : '{dst: dec.dst, ld: dec.is_ld};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      sb1_q   <= '0;
      sb2_q   <= '0;
      sb3_q   <= '0;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sb1_q   <= push;
      sb2_q   <= sb1_q;
      sb3_q   <= sb2_q;
      fwd_a_q <= idex_bubble ? FWD_REG : fwd_sel(dec.src_a, dec.use_a, sb1_q, sb2_q, sb3_q);
      fwd_b_q <= idex_bubble ? FWD_REG : fwd_sel(dec.src_b, dec.use_b, sb1_q, sb2_q, sb3_q);
      if (pc_hold && stall_q != '1)    stall_q <= stall_q + 1'b1;
      if (ifid_flush && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign state_o   = state_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Monitors the instruction entering decode and tracks in-flight destination registers in a 3-deep scoreboard covering EX, MEM and WB.
- Generates PC/IF-ID hold, ID-EX bubble, IF-ID flush and per-operand forwarding selects.
- Counts stall and flush cycles for performance readout.

Parameters:
- LOAD_LAT, 1: load-use stall cycles inserted per hazard (1..3).
- FLUSH_LEN, 2: total cycles flush is asserted after a taken beq (1..3).
- CNT_W, 16: width of the saturating performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- if_ir  in  32  instruction presented to decode this cycle
- if_valid  in  1  if_ir is a real instruction; when 0, if_ir is treated as a nop
- ex_br_taken  in  1  beq in EX resolved taken this cycle
- pc_hold  out  1  hold PC and the IF/ID register (combinational)
- ifid_flush  out  1  replace the IF/ID content with a nop (combinational)
- idex_bubble  out  1  load a nop into ID/EX at the next edge (combinational)
- fwd_a  out  2  rs operand source for the instruction now in EX (registered)
- fwd_b  out  2  rt operand source for the instruction now in EX (registered)
- state_o  out  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH
- stall_cnt  out  CNT_W  saturating count of pc_hold cycles
- flush_cnt  out  CNT_W  saturating count of ifid_flush cycles

Behaviour:
- Decode of if_ir:
  - opcode 0 with funct 32/34/42: sources rs, rt; destination rd.
  - opcode 35 (lw): source rs; destination rt; load flag set.
  - opcode 43 (sw): sources rs, rt; no destination.
  - opcode 4 (beq): sources rs, rt; no destination.
  - opcode 2 (j): no sources, no destination; marked as jump.
  - Anything else, or if_valid=0: nop.
  - A source or destination equal to register 0 never matches anything.
- Scoreboard: entries sb[1..3], each {dst[4:0], ld}. At every edge, sb[3]<=sb[2], sb[2]<=sb[1], and sb[1]<=push. push is the decoded destination, or zero when idex_bubble=1.
- Forwarding:
  - Computed per source at decode; registered into fwd_a/fwd_b at the edge where the instruction enters EX.
  - Youngest match wins: sb[1] -> 1 (MEM result), sb[2] -> 2 (WB result), sb[3] -> 3 (same-edge regfile write bypass), else 0 (regfile).
  - When idex_bubble=1, fwd_a and fwd_b register 0.
- Load-use hazard: a decode source matches sb[1].dst and sb[1].ld=1.
- FSM; a counter cnt (2 bits) is used in STALL and FLUSH.
  - RUN:
    - ex_br_taken=1: assert ifid_flush and idex_bubble. Go to FLUSH with cnt=FLUSH_LEN-1, or stay in RUN if FLUSH_LEN=1.
    - Else, load-use hazard: assert pc_hold and idex_bubble. Go to STALL with cnt=LOAD_LAT-1, or stay in RUN if LOAD_LAT=1; hazard is re-evaluated next cycle.
    - Else, jump decoded: assert ifid_flush only for this one cycle.
  - STALL: assert pc_hold and idex_bubble; decrement cnt; return to RUN when cnt=0. ex_br_taken during STALL takes priority: behave as in RUN and go to FLUSH.
  - FLUSH: assert ifid_flush and idex_bubble; decrement cnt; return to RUN when cnt=0. Hazards and jumps are ignored; ex_br_taken reloads cnt=FLUSH_LEN-1.
- Simultaneous events: branch beats load-use, and load-use beats jump. pc_hold and ifid_flush are never both 1.
- Counters: stall_cnt increments on every cycle with pc_hold=1, flush_cnt on every cycle with ifid_flush=1. Both saturate at all-ones.
- Reset (valid at any time, including mid-stall or mid-flush): state RUN, cnt 0, scoreboard cleared, fwd_a=fwd_b=0, both counters 0. Combinational outputs therefore read 0 in the first cycle after reset, unless inputs create a hazard.

Decomposition:
- Shared package cpu_pkg: opcode constants (OP_RTYPE 0, OP_LW 35, OP_SW 43, OP_BEQ 4, OP_J 2), funct constants (32/34/42), FSM state encodings, and fwd select encodings (FWD_REG 0, FWD_MEM 1, FWD_WB 2, FWD_WBYP 3).
- One sub-module, hz_decode: combinational if_ir -> {src_a, src_b, use_a, use_b, dst, is_ld, is_j}.

Test Plan:
- Forwarding: add $3,$1,$2, then sub $4,$3,$5, then add $6,$3,$3 back-to-back. Expect fwd_a=1 with the sub in EX; fwd_a=2 and fwd_b=2 with the second add in EX; no pc_hold.
- Load-use: lw $8,0($1), then add $9,$8,$2. Expect exactly one cycle with pc_hold=idex_bubble=1; fwd_a=2 when the add reaches EX; stall_cnt=1.
- Taken branch: ex_br_taken pulse in RUN with FLUSH_LEN=2. Expect ifid_flush=idex_bubble=1 for 2 cycles, state_o 0->2->0, flush_cnt=2.
- Branch during load stall: LOAD_LAT=2, ex_br_taken in the second stall cycle. Expect the FSM to go STALL->FLUSH, pc_hold drop in that cycle, and stall_cnt=1.
- Jump plus $0: j, then add $0,.. followed by a reader of $0. Expect a 1-cycle ifid_flush, no forwarding (fwd=0) and no stall for $0.
- Reset and saturation: assert rst mid-FLUSH -> all registered outputs 0 and state RUN at the next edge. With CNT_W=2, force 5 stall cycles -> stall_cnt holds at 3.
